// File: rtl/pagerank_reducer_if.sv
// Stream bundle between the PageRank mapper, the reducer and the rank consumer.
// slave is the reducer's view; master is the view of the surrounding logic.
interface pagerank_reducer_if #(
    parameter int nbits = 32,
    parameter int iw    = 3
) ();
    logic             in_val;
    logic             in_rdy;
    logic [nbits-1:0] in_msg;
    logic             out_val;
    logic             out_rdy;
    logic [nbits-1:0] out_msg;
    logic [iw-1:0]    out_idx;
    logic             done;

    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_msg, out_idx, done
    );

    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_msg, out_idx, done
    );
endinterface

// File: rtl/pagerank_reducer.sv
// PageRank reducer: sums nparts consecutive partial dot products into one
// rank per node, emits it tagged with the node index, walks nodes
// 0..nnodes-1 and pulses done once the last node of an iteration is taken.
module pagerank_reducer #(
    parameter int nbits  = 32,
    parameter int nparts = 4,
    parameter int nnodes = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    pagerank_reducer_if.slave  bus
);
    localparam int iw = (nnodes > 1) ? $clog2(nnodes) : 1;
    localparam int cw = (nparts > 1) ? $clog2(nparts) : 1;

    localparam logic [cw-1:0] cnt_last  = cw'(nparts - 1);
    localparam logic [iw-1:0] node_last = iw'(nnodes - 1);

    localparam logic [0:0] ACC = 1'b0;
    localparam logic [0:0] OUT = 1'b1;

    logic [0:0]       state;
    logic [nbits-1:0] acc;
    logic [cw-1:0]    cnt;
    logic [iw-1:0]    node;
    logic [nbits-1:0] out_msg;
    logic [iw-1:0]    out_idx;
    logic             done;

    logic             in_fire;
    logic             out_fire;
    logic             last_part;
    logic [nbits-1:0] acc_sum;

    // Handshake qualifiers and the running sum including the incoming partial
    // (carries beyond nbits are dropped on purpose: modulo arithmetic).
    always_comb begin
        in_fire   = (state == ACC) && bus.in_val;
        out_fire  = (state == OUT) && bus.out_rdy;
        last_part = (cnt == cnt_last);
        acc_sum   = acc + bus.in_msg;
    end

    // Two-state control: collect partials in ACC, hold the result in OUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACC;
        end else if (clear) begin
            state <= ACC;
        end else if (in_fire && last_part) begin
            state <= OUT;
        end else if (out_fire) begin
            state <= ACC;
        end
    end

    // Accumulator and partial counter; both restart when a node is complete.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_fire) begin
            if (last_part) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Result register: captured on the last partial, then held through any
    // backpressure until the consumer takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_msg <= '0;
            out_idx <= '0;
        end else if (!clear && in_fire && last_part) begin
            out_msg <= acc_sum;
            out_idx <= node;
        end
    end

    // Node walker; done is registered so it shows up the cycle after the
    // handshake that retired the final node of the iteration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            node <= '0;
            done <= 1'b0;
        end else if (clear) begin
            node <= '0;
            done <= 1'b0;
        end else if (out_fire) begin
            if (node == node_last) begin
                node <= '0;
                done <= 1'b1;
            end else begin
                node <= node + 1'b1;
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign bus.in_rdy  = (state == ACC);
    assign bus.out_val = (state == OUT);
    assign bus.out_msg = out_msg;
    assign bus.out_idx = out_idx;
    assign bus.done    = done;
endmodule

// File: tb/tb_pagerank_reducer.sv
// Bench for pagerank_reducer (nparts=4, nnodes=3, nbits=32): directed cases
// with literal expectations, then a randomized run, all shadowed by a
// transaction-level model compared every cycle.
module tb_pagerank_reducer;
    localparam int NBITS  = 32;
    localparam int NPARTS = 4;
    localparam int NNODES = 3;
    localparam int IW     = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    pagerank_reducer_if #(.nbits(NBITS), .iw(IW)) bus ();

    pagerank_reducer #(.nbits(NBITS), .nparts(NPARTS), .nnodes(NNODES)) dut (
        .clk   (clk),
        .reset (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Partials of the node in progress are kept as a list; when the list
    // reaches nparts entries their modular sum becomes the pending result.
    logic [NBITS-1:0] part_q[$];
    bit               m_pend;
    bit               m_done;
    logic [NBITS-1:0] m_msg;
    int               m_idx;
    int               m_node;

    function automatic logic [NBITS-1:0] sum_with(input logic [NBITS-1:0] last);
        logic [NBITS-1:0] s;
        s = last;
        foreach (part_q[i]) s = s + part_q[i];
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_q.delete();
            m_pend <= 0;
            m_done <= 0;
            m_msg  <= '0;
            m_idx  <= 0;
            m_node <= 0;
        end else begin
            m_done <= 0;
            if (clear) begin
                part_q.delete();
                m_pend <= 0;
                m_node <= 0;
            end else if (m_pend) begin
                if (bus.out_rdy) begin
                    m_pend <= 0;
                    if (m_node == NNODES - 1) begin
                        m_node <= 0;
                        m_done <= 1;
                    end else begin
                        m_node <= m_node + 1;
                    end
                end
            end else if (bus.in_val) begin
                if (part_q.size() == NPARTS - 1) begin
                    m_msg  <= sum_with(bus.in_msg);
                    m_idx  <= m_node;
                    m_pend <= 1;
                    part_q.delete();
                end else begin
                    part_q.push_back(bus.in_msg);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    int idx_w;
    always @(negedge clk) begin
        chk("out_val", {63'd0, bus.out_val}, {63'd0, m_pend});
        chk("in_rdy", {63'd0, bus.in_rdy}, {63'd0, !m_pend});
        chk("done", {63'd0, bus.done}, {63'd0, m_done});
        if (m_pend) begin
            idx_w = m_idx;
            chk("out_msg", {32'd0, bus.out_msg}, {32'd0, m_msg});
            chk("out_idx", {62'd0, bus.out_idx}, {62'd0, idx_w[1:0]});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one partial and hold it until the edge that accepts it.
    task automatic send(input logic [NBITS-1:0] v);
        bit ok;
        int budget;
        bus.in_val = 1'b1;
        bus.in_msg = v;
        budget = 50;
        ok = 0;
        while (!ok && budget > 0) begin
            ok = bus.in_rdy;
            step();
            budget--;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        bus.in_val = 1'b0;
    endtask

    task automatic send4(input logic [NBITS-1:0] a, b, c, d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    int outs_seen = 0;
    always @(posedge clk) if (bus.out_val && bus.out_rdy) outs_seen++;

    initial begin
        bus.in_val  = 1'b0;
        bus.in_msg  = '0;
        bus.out_rdy = 1'b0;

        // 1. reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_val", {63'd0, bus.out_val}, 64'd0);
        chk("rst_out_msg", {32'd0, bus.out_msg}, 64'd0);
        chk("rst_out_idx", {62'd0, bus.out_idx}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_rdy", {63'd0, bus.in_rdy}, 64'd1);

        // 2. back-to-back 1,2,3,4 with out_rdy high
        bus.out_rdy = 1'b1;
        send4(32'd1, 32'd2, 32'd3, 32'd4);
        chk("t2_out_val", {63'd0, bus.out_val}, 64'd1);
        chk("t2_out_msg", {32'd0, bus.out_msg}, 64'd10);
        chk("t2_out_idx", {62'd0, bus.out_idx}, 64'd0);
        chk("t2_in_rdy", {63'd0, bus.in_rdy}, 64'd0);
        step();
        chk("t2_back_acc", {63'd0, bus.in_rdy}, 64'd1);

        // 3. same partials, 5 cycles of backpressure
        bus.out_rdy = 1'b0;
        send4(32'd1, 32'd2, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_msg", {32'd0, bus.out_msg}, 64'd10);
            chk("t3_hold_rdy", {63'd0, bus.in_rdy}, 64'd0);
            step();
        end
        bus.out_rdy = 1'b1;
        step();
        chk("t3_out_val", {63'd0, bus.out_val}, 64'd0);
        chk("t3_in_rdy", {63'd0, bus.in_rdy}, 64'd1);

        // 4. wrap-around (node 2, so this also ends the iteration)
        send4(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        chk("t4_wrap", {32'd0, bus.out_msg}, 64'd1);
        chk("t4_idx", {62'd0, bus.out_idx}, 64'd2);
        step();
        chk("t4_done", {63'd0, bus.done}, 64'd1);

        // 5. three nodes of 5s after a clear
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int n = 0; n < 3; n++) begin
            send4(32'd5, 32'd5, 32'd5, 32'd5);
            chk("t5_msg", {32'd0, bus.out_msg}, 64'd20);
            chk("t5_idx", {62'd0, bus.out_idx}, 64'(n));
            chk("t5_no_done", {63'd0, bus.done}, 64'd0);
            step();
        end
        chk("t5_done", {63'd0, bus.done}, 64'd1);
        step();
        chk("t5_done_pulse", {63'd0, bus.done}, 64'd0);
        send4(32'd5, 32'd5, 32'd5, 32'd5);
        chk("t5_wrap_idx", {62'd0, bus.out_idx}, 64'd0);
        step();

        // 6. clear drops earlier partials and the same-cycle input
        send(32'd7);
        send(32'd7);
        clear = 1'b1;
        bus.in_val = 1'b1;
        bus.in_msg = 32'd7;
        step();
        clear = 1'b0;
        bus.in_val = 1'b0;
        send4(32'd1, 32'd1, 32'd1, 32'd1);
        chk("t6_msg", {32'd0, bus.out_msg}, 64'd4);
        chk("t6_idx", {62'd0, bus.out_idx}, 64'd0);
        step();

        // 1b. asynchronous reset while holding a result in OUT
        bus.out_rdy = 1'b0;
        send4(32'd9, 32'd9, 32'd9, 32'd9);
        chk("t1b_pre_val", {63'd0, bus.out_val}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1b_async_val", {63'd0, bus.out_val}, 64'd0);
        chk("t1b_async_msg", {32'd0, bus.out_msg}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t1b_in_rdy", {63'd0, bus.in_rdy}, 64'd1);

        // randomized traffic checked by the model
        for (int c = 0; c < 2000; c++) begin
            bus.in_val  = ($urandom % 3) != 0;
            bus.in_msg  = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom;
            bus.out_rdy = ($urandom % 4) != 0;
            clear       = ($urandom % 97) == 0;
            step();
        end
        bus.in_val = 1'b0;
        clear = 1'b0;
        step();
        chk("rand_activity", {63'd0, outs_seen > 100}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
